// File: rtl/z80_bus_fixup_if.sv
// Bus bundle between the Z80 core, the fixup block and the system data buses.
// The master modport is the core/system side, the slave modport is the fixup block.
interface z80_bus_fixup_if;
    logic       m1_n;
    logic       mreq_n;
    logic       iorq_n;
    logic       rd_n;
    logic       wr_n;
    logic [7:0] core_dout;
    logic [7:0] sys_di;
    logic [7:0] core_din;
    logic [7:0] sys_dout;

    modport master (
        output m1_n, mreq_n, iorq_n, rd_n, wr_n, core_dout, sys_di,
        input  core_din, sys_dout
    );

    modport slave (
        input  m1_n, mreq_n, iorq_n, rd_n, wr_n, core_dout, sys_di,
        output core_din, sys_dout
    );
endinterface

// File: rtl/z80_bus_fixup.sv
// Z80 bus fixup: substitutes the data byte of OUT (C),0 (ED 71) with a
// selectable NMOS/CMOS value, injects the IM2 vector on interrupt
// acknowledge, and provides debug strobes plus a saturating patch counter.
module z80_bus_fixup #(
    parameter logic [7:0]  NMOS_VAL       = 8'h00,
    parameter logic [7:0]  CMOS_VAL       = 8'hFF,
    parameter logic [7:0]  INTACK_DEFAULT = 8'hFF,
    parameter logic [7:0]  BUS_IDLE       = 8'hFF,
    parameter int unsigned ARM_TIMEOUT    = 16,
    parameter int unsigned CNT_W          = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    z80_bus_fixup_if.slave     bus,
    input  logic               patch_en,
    input  logic               cmos_mode,
    input  logic               vec_en,
    input  logic [7:0]         im2_vector,
    output logic               patch_active,
    output logic               patch_stb,
    output logic               intack_stb,
    output logic [CNT_W-1:0]   patch_count
);

    // Timer only needs to reach ARM_TIMEOUT-1; one spare bit keeps the
    // width sane for tiny or zero timeouts.
    localparam int unsigned     TMR_W    = $clog2(ARM_TIMEOUT + 2);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((ARM_TIMEOUT == 0) ? 0 : (ARM_TIMEOUT - 1));

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_OP1   = 3'd1,
        S_EDW   = 3'd2,
        S_OP2   = 3'd3,
        S_ARMED = 3'd4,
        S_PATCH = 3'd5
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic               m1_q_r;
    logic               intack_q_r;
    logic [7:0]         opcode_r;
    logic [TMR_W-1:0]   timer_r;
    logic               patch_stb_r;
    logic               intack_stb_r;
    logic [CNT_W-1:0]   patch_count_r;

    logic               fetch_s;
    logic               intack_s;
    logic               m1_rise_s;
    logic               patch_done_s;
    logic               patch_active_s;
    logic [7:0]         core_din_s;
    logic [7:0]         sys_dout_s;
    logic               unused_s;

    // WR is part of the bus bundle but the write data path does not depend on it.
    assign unused_s = bus.wr_n;

    assign fetch_s      = !bus.m1_n && !bus.mreq_n && !bus.rd_n;
    assign intack_s     = !bus.m1_n && !bus.iorq_n;
    assign m1_rise_s    = !m1_q_r && bus.m1_n;
    assign patch_done_s = (state_r == S_PATCH) && bus.iorq_n;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode of the ED 71 sequence; DD/FD prefixes fall back to idle and re-decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (fetch_s) state_s = S_OP1;
                else         state_s = S_IDLE;
            end
            S_OP1: begin
                if (m1_rise_s) begin
                    if (opcode_r == 8'hED) state_s = S_EDW;
                    else                   state_s = S_IDLE;
                end else begin
                    state_s = S_OP1;
                end
            end
            S_EDW: begin
                if (fetch_s) state_s = S_OP2;
                else         state_s = S_EDW;
            end
            S_OP2: begin
                if (m1_rise_s) begin
                    if (opcode_r == 8'h71) state_s = S_ARMED;
                    else                   state_s = S_IDLE;
                end else begin
                    state_s = S_OP2;
                end
            end
            S_ARMED: begin
                if (!bus.iorq_n && bus.m1_n)                      state_s = S_PATCH;
                else if (fetch_s)                                 state_s = S_OP1;
                else if ((ARM_TIMEOUT != 0) && (timer_r == TMR_LAST)) state_s = S_IDLE;
                else                                              state_s = S_ARMED;
            end
            S_PATCH: begin
                if (bus.iorq_n) state_s = S_IDLE;
                else            state_s = S_PATCH;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Bus outputs: patched write data and the byte presented to the core.
    always_comb begin
        patch_active_s = patch_en && ((state_r == S_ARMED) || (state_r == S_PATCH));
        if (patch_active_s) begin
            sys_dout_s = cmos_mode ? CMOS_VAL : NMOS_VAL;
        end else begin
            sys_dout_s = bus.core_dout;
        end
        if (intack_s) begin
            core_din_s = vec_en ? im2_vector : INTACK_DEFAULT;
        end else if (!bus.rd_n) begin
            core_din_s = bus.sys_di;
        end else begin
            core_din_s = BUS_IDLE;
        end
    end

    assign bus.core_din  = core_din_s;
    assign bus.sys_dout  = sys_dout_s;
    assign patch_active  = patch_active_s;

    // Edge-detect history and the opcode as actually seen by the core.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            m1_q_r     <= 1'b1;
            intack_q_r <= 1'b0;
            opcode_r   <= 8'h00;
        end else begin
            m1_q_r     <= bus.m1_n;
            intack_q_r <= intack_s;
            if (fetch_s) begin
                opcode_r <= core_din_s;
            end else begin
                opcode_r <= opcode_r;
            end
        end
    end

    // Arm timeout: held at zero outside S_ARMED so every entry starts from zero.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            timer_r <= {TMR_W{1'b0}};
        end else if (state_r == S_ARMED) begin
            timer_r <= timer_r + TMR_W'(1);
        end else begin
            timer_r <= {TMR_W{1'b0}};
        end
    end

    // Debug strobes and saturating count of completed patches.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            patch_stb_r   <= 1'b0;
            intack_stb_r  <= 1'b0;
            patch_count_r <= {CNT_W{1'b0}};
        end else begin
            patch_stb_r  <= patch_done_s;
            intack_stb_r <= intack_s && !intack_q_r;
            if (patch_done_s && (patch_count_r != {CNT_W{1'b1}})) begin
                patch_count_r <= patch_count_r + CNT_W'(1);
            end else begin
                patch_count_r <= patch_count_r;
            end
        end
    end

    assign patch_stb   = patch_stb_r;
    assign intack_stb  = intack_stb_r;
    assign patch_count = patch_count_r;

endmodule

// File: tb/tb_z80_bus_fixup.sv
// Scoreboard bench for z80_bus_fixup: stimulus pushes expectations into
// queues, a monitor on the falling edge pops and compares them.
module tb_z80_bus_fixup;

    localparam int P_ACTIVE = 0;
    localparam int P_COUNT  = 1;
    localparam int P_PSTB   = 2;
    localparam int P_ISTB   = 3;
    localparam int P_SDOUT  = 4;
    localparam int P_CDIN   = 5;

    typedef struct {
        string       name;
        int          sel;
        logic [15:0] exp;
    } probe_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       patch_en;
    logic       cmos_mode;
    logic       vec_en;
    logic [7:0] im2_vector;
    logic       patch_active;
    logic       patch_stb;
    logic       intack_stb;
    logic [7:0] patch_count;

    z80_bus_fixup_if bus ();

    z80_bus_fixup dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus),
        .patch_en     (patch_en),
        .cmos_mode    (cmos_mode),
        .vec_en       (vec_en),
        .im2_vector   (im2_vector),
        .patch_active (patch_active),
        .patch_stb    (patch_stb),
        .intack_stb   (intack_stb),
        .patch_count  (patch_count)
    );

    always #5 clk = ~clk;

    probe_t     probe_q[$];
    logic [7:0] io_q[$];
    logic [7:0] patch_q[$];
    logic [7:0] intack_q[$];
    int         exp_cnt = 0;
    bit         stim_done = 1'b0;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input string name, input int sel, input logic [15:0] exp);
        probe_t p;
        p.name = name;
        p.sel  = sel;
        p.exp  = exp;
        probe_q.push_back(p);
    endtask

    task automatic fetch(input logic [7:0] op);
        bus.m1_n = 1'b0; bus.mreq_n = 1'b0; bus.rd_n = 1'b0; bus.sys_di = op;
        tick(); tick();
        bus.m1_n = 1'b1; bus.mreq_n = 1'b1; bus.rd_n = 1'b1; bus.sys_di = 8'hFF;
        tick(); tick();
    endtask

    task automatic io_write(input logic [7:0] data, input logic [7:0] exp_dout, input bit patch_evt);
        io_q.push_back(exp_dout);
        if (patch_evt) begin
            if (exp_cnt < 255) exp_cnt++;
            patch_q.push_back(8'(exp_cnt));
        end
        bus.core_dout = data;
        tick();
        bus.iorq_n = 1'b0; bus.wr_n = 1'b0;
        tick(); tick(); tick();
        bus.iorq_n = 1'b1; bus.wr_n = 1'b1;
        tick();
    endtask

    task automatic intack(input logic [7:0] exp_vec);
        intack_q.push_back(exp_vec);
        bus.m1_n = 1'b0;
        tick();
        bus.iorq_n = 1'b0;
        tick(); tick(); tick();
        bus.m1_n = 1'b1; bus.iorq_n = 1'b1;
        tick(); tick();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        exp_cnt = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_n = 1'b0;
        patch_en = 1'b1; cmos_mode = 1'b0; vec_en = 1'b0; im2_vector = 8'h00;
        bus.m1_n = 1'b1; bus.mreq_n = 1'b1; bus.iorq_n = 1'b1;
        bus.rd_n = 1'b1; bus.wr_n = 1'b1;
        bus.core_dout = 8'hA5; bus.sys_di = 8'hFF;
        tick(); tick();
        probe("rst_active", P_ACTIVE, 16'h0000);
        probe("rst_count",  P_COUNT,  16'h0000);
        probe("rst_pstb",   P_PSTB,   16'h0000);
        probe("rst_istb",   P_ISTB,   16'h0000);
        probe("rst_sdout",  P_SDOUT,  16'h00A5);
        probe("rst_cdin",   P_CDIN,   16'h00FF);
        tick();
        reset_n = 1'b1;
        tick();

        // NMOS patch
        fetch(8'hED); fetch(8'h71);
        probe("nmos_armed", P_ACTIVE, 16'h0001);
        tick();
        io_write(8'h55, 8'h00, 1'b1);
        probe("nmos_after", P_ACTIVE, 16'h0000);
        tick();

        // CMOS patch
        cmos_mode = 1'b1;
        fetch(8'hED); fetch(8'h71);
        io_write(8'h55, 8'hFF, 1'b1);
        cmos_mode = 1'b0;

        // Disabled substitution still counts
        patch_en = 1'b0;
        fetch(8'hED); fetch(8'h71);
        probe("dis_armed", P_ACTIVE, 16'h0000);
        tick();
        io_write(8'h55, 8'h55, 1'b1);
        patch_en = 1'b1;

        // DD ED 71 is patched
        fetch(8'hDD); fetch(8'hED); fetch(8'h71);
        probe("dd_armed", P_ACTIVE, 16'h0001);
        tick();
        io_write(8'h55, 8'h00, 1'b1);

        // ED 70 is not patched
        fetch(8'hED); fetch(8'h70);
        probe("ed70_idle", P_ACTIVE, 16'h0000);
        tick();
        io_write(8'h55, 8'h55, 1'b0);

        // ED ED 71 is not patched
        fetch(8'hED);
        probe("eded_1", P_ACTIVE, 16'h0000);
        fetch(8'hED);
        probe("eded_2", P_ACTIVE, 16'h0000);
        fetch(8'h71);
        probe("eded_3", P_ACTIVE, 16'h0000);
        tick();
        io_write(8'h55, 8'h55, 1'b0);

        // Interrupt acknowledge
        vec_en = 1'b1; im2_vector = 8'h3C;
        intack(8'h3C);
        vec_en = 1'b0;
        intack(8'hFF);
        probe("ack_idle", P_ACTIVE, 16'h0000);
        tick();
        io_write(8'h55, 8'h55, 1'b0);

        // Timeout: active for exactly 16 cycles of S_ARMED
        fetch(8'hED); fetch(8'h71);
        for (int i = 0; i < 20; i++) begin
            probe("timeout", P_ACTIVE, (i <= 14) ? 16'h0001 : 16'h0000);
            tick();
        end
        io_write(8'h55, 8'h55, 1'b0);

        // Abort by fetch of 3E
        fetch(8'hED); fetch(8'h71);
        probe("abort_armed", P_ACTIVE, 16'h0001);
        tick();
        fetch(8'h3E);
        probe("abort_3e", P_ACTIVE, 16'h0000);
        tick();
        io_write(8'h55, 8'h55, 1'b0);

        // Abort by ED which is re-decoded into a new ED 71
        fetch(8'hED); fetch(8'h71); fetch(8'hED); fetch(8'h71);
        probe("redecode", P_ACTIVE, 16'h0001);
        tick();
        io_write(8'h55, 8'h00, 1'b1);

        // Reset while in S_PATCH with count 5
        do_reset();
        for (int i = 0; i < 5; i++) begin
            fetch(8'hED); fetch(8'h71);
            io_write(8'h55, 8'h00, 1'b1);
        end
        fetch(8'hED); fetch(8'h71);
        io_q.push_back(8'h00);
        bus.core_dout = 8'h55;
        tick();
        bus.iorq_n = 1'b0; bus.wr_n = 1'b0;
        tick();
        probe("mid_active", P_ACTIVE, 16'h0001);
        probe("mid_count",  P_COUNT,  16'h0005);
        tick();
        reset_n = 1'b0; bus.iorq_n = 1'b1; bus.wr_n = 1'b1;
        tick();
        reset_n = 1'b1;
        exp_cnt = 0;
        probe("post_active", P_ACTIVE, 16'h0000);
        probe("post_count",  P_COUNT,  16'h0000);
        probe("post_pstb",   P_PSTB,   16'h0000);
        tick(); tick();

        // Saturation
        for (int i = 0; i < 300; i++) begin
            fetch(8'hED); fetch(8'h71);
            io_write(8'h55, 8'h00, 1'b1);
        end
        tick();
        probe("sat_count", P_COUNT, 16'h00FF);
        tick(); tick();
        stim_done = 1'b1;
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [7:0]  cur_io;
        logic [7:0]  cur_vec;
        logic [7:0]  exp_c;
        logic [15:0] act;
        bit          iowr_prev;
        bit          ack_prev;
        bit          ack_pending;
        bit          iowr;
        bit          ack;
        int          cycles;
        probe_t      p;
        cur_io = 8'h00; cur_vec = 8'h00;
        iowr_prev = 1'b0; ack_prev = 1'b0; ack_pending = 1'b0;
        cycles = 0;
        forever begin
            @(negedge clk);
            cycles++;
            if (stim_done) begin
                chk("patch_queue_drained", 16'(patch_q.size()), 16'd0);
                chk("io_queue_drained", 16'(io_q.size()), 16'd0);
                chk("intack_stb_seen", {15'd0, ack_pending}, 16'd0);
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
            if (cycles > 30000) begin
                chk("watchdog", 16'd1, 16'd0);
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end

            while (probe_q.size() > 0) begin
                p = probe_q.pop_front();
                case (p.sel)
                    P_ACTIVE: act = {15'd0, patch_active};
                    P_COUNT:  act = {8'd0, patch_count};
                    P_PSTB:   act = {15'd0, patch_stb};
                    P_ISTB:   act = {15'd0, intack_stb};
                    P_SDOUT:  act = {8'd0, bus.sys_dout};
                    P_CDIN:   act = {8'd0, bus.core_din};
                    default:  act = 16'hDEAD;
                endcase
                chk(p.name, act, p.exp);
            end

            if (patch_stb === 1'b1) begin
                chk("patch_stb_expected", 16'(patch_q.size()), 16'd1);
                if (patch_q.size() > 0) begin
                    exp_c = patch_q.pop_front();
                    chk("patch_count", {8'd0, patch_count}, {8'd0, exp_c});
                end
            end

            iowr = (bus.iorq_n === 1'b0) && (bus.wr_n === 1'b0) && (bus.m1_n === 1'b1);
            if (iowr && !iowr_prev) begin
                chk("io_expected", 16'(io_q.size()), 16'd1);
                if (io_q.size() > 0) cur_io = io_q.pop_front();
            end
            if (iowr) chk("sys_dout", {8'd0, bus.sys_dout}, {8'd0, cur_io});
            iowr_prev = iowr;

            if (intack_stb === 1'b1) begin
                chk("intack_stb_once", {15'd0, ack_pending}, 16'd1);
                ack_pending = 1'b0;
            end
            ack = (bus.m1_n === 1'b0) && (bus.iorq_n === 1'b0);
            if (ack && !ack_prev) begin
                chk("intack_expected", 16'(intack_q.size()), 16'd1);
                if (intack_q.size() > 0) cur_vec = intack_q.pop_front();
                ack_pending = 1'b1;
            end
            if (ack) chk("core_din_ack", {8'd0, bus.core_din}, {8'd0, cur_vec});
            ack_prev = ack;
        end
    end

endmodule

// File: doc/z80_bus_fixup.md
Name: z80_bus_fixup

Overview:
- Parametrised bus-fixup block between the Z80 core and the system data buses.
- Generalises the fixed OUT (C),0 patch: selectable patch value for NMOS or CMOS behaviour, a runtime enable, and an abort/timeout path.
- Also supplies IM2 vector injection on interrupt acknowledge, plus event strobes and a saturating patch counter for debug.
- Fully synchronous to the CPU clock.

Parameters:
- NMOS_VAL, 8'h00: byte driven during OUT (C),0 when cmos_mode=0.
- CMOS_VAL, 8'hFF: byte driven during OUT (C),0 when cmos_mode=1.
- INTACK_DEFAULT, 8'hFF: byte presented on interrupt acknowledge when vec_en=0.
- BUS_IDLE, 8'hFF: byte presented to the core when nothing drives it.
- ARM_TIMEOUT, 16: clk cycles S_ARMED waits for IORQ before abandoning; 0 disables the timeout.
- CNT_W, 8: width of patch_count.

Ports:
- clk  in  1  CPU clock.
- reset_n  in  1  synchronous, active-low reset.
- m1_n  in  1  core M1.
- mreq_n  in  1  core MREQ.
- iorq_n  in  1  core IORQ.
- rd_n  in  1  core RD.
- wr_n  in  1  core WR.
- core_dout  in  8  data written by the core.
- sys_di  in  8  data read from the system.
- patch_en  in  1  enables the OUT (C),0 substitution.
- cmos_mode  in  1  selects CMOS_VAL (1) or NMOS_VAL (0).
- vec_en  in  1  use im2_vector on interrupt acknowledge.
- im2_vector  in  8  IM2 vector byte.
- core_din  out  8  data presented to the core.
- sys_dout  out  8  data presented to the system.
- patch_active  out  1  high while the substitution is applied.
- patch_stb  out  1  one-cycle pulse when a patched I/O write completes.
- intack_stb  out  1  one-cycle pulse on the first cycle of each interrupt acknowledge.
- patch_count  out  CNT_W  saturating count of completed patches.

Behaviour:
- Clock and reset: clk is the clock; reset_n is synchronous and active-low.
- Decode terms:
  - fetch = !m1_n & !mreq_n & !rd_n.
  - intack = !m1_n & !iorq_n.
  - m1_rise = m1_q==0 & m1_n==1, where m1_q is m1_n registered.
- Opcode latch: opcode <= core_din on every cycle where fetch is true. The latched value is the byte the core actually received.
- core_din (combinational):
  - intack: (vec_en ? im2_vector : INTACK_DEFAULT).
  - else !rd_n: sys_di.
  - else: BUS_IDLE.
- sys_dout (combinational): (patch_active ? (cmos_mode ? CMOS_VAL : NMOS_VAL) : core_dout).
- patch_active = patch_en & (state==S_ARMED | state==S_PATCH). Deasserting patch_en does not disturb the FSM.
- FSM states and transitions:
  - S_IDLE: fetch -> S_OP1.
  - S_OP1: on m1_rise, opcode==ED -> S_EDW, otherwise -> S_IDLE. DD/FD prefixes therefore pass through transparently, so DD ED 71 is still detected.
  - S_EDW: fetch -> S_OP2.
  - S_OP2: on m1_rise, opcode==71 -> S_ARMED, otherwise -> S_IDLE. ED ED 71 is not patched.
  - S_ARMED:
    - !iorq_n & m1_n -> S_PATCH.
    - Else fetch (IORQ never came) -> S_OP1; the fetch is re-decoded.
    - Else timer==ARM_TIMEOUT-1 with ARM_TIMEOUT!=0 -> S_IDLE.
  - S_PATCH: iorq_n==1 -> S_IDLE. On this transition patch_stb=1 and patch_count increments, saturating at all-ones.
- Timeout timer: clears on entry to S_ARMED and increments each cycle spent in S_ARMED.
- Interrupt acknowledge cycles never advance the FSM, because mreq_n is high.
- intack_stb fires when intack is true and was false on the previous cycle.
- Priority: if iorq and fetch are both seen in S_ARMED, iorq wins.
- Reset (including mid-operation):
  - state=S_IDLE, opcode=00, timer=0, m1_q=1.
  - patch_count=0, patch_stb=0, intack_stb=0.
  - patch_active is therefore 0 and sys_dout=core_dout.

Test Plan:
- Fetch ED then 71, then an I/O write with core_dout=55, cmos_mode=0, patch_en=1 -> sys_dout=00 throughout ARMED/PATCH; a single patch_stb on IORQ release; patch_count=1.
- Same sequence with cmos_mode=1 -> sys_dout=FF; with patch_en=0 -> sys_dout=55, but patch_stb still pulses and patch_count still increments.
- Fetch DD, ED, 71 -> patched. Fetch ED, 70 -> no patch. Fetch ED, ED, 71 -> no patch, patch_active never asserts.
- Interrupt acknowledge with vec_en=1, im2_vector=3C -> core_din=3C for the whole ack and one intack_stb; with vec_en=0 -> core_din=FF; FSM stays in S_IDLE.
- ARM_TIMEOUT=16, ED 71 with no IORQ for 20 cycles -> patch_active drops after 16 cycles. In a separate run, a fetch of 3E while ARMED -> abort, patch_active drops, 3E is re-decoded.
- Assert reset_n=0 for one cycle while in S_PATCH with patch_count=5 -> next cycle state S_IDLE, patch_active=0, patch_count=0, no patch_stb. Also: 300 patches with CNT_W=8 -> patch_count saturates at FF.
